muldiv_hilo_sequencer: RTL and testbench

Multi-cycle multiply/divide controller that owns the Hi/Lo register pair of the pipelined MIPS core. It sits beside the EX stage and accepts MULT/MULTU/DIV/DIVU/MADD/MSUB/MTHI/MTLO/MFHI/MFLO operations. It sequences a multi-cycle multiplier and a serial divider, and asserts Stall to the hazard unit when a dependent or conflicting op arrives while busy. HiData/LoData drive the core's top-level HiData/LoData debug outputs.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_serial_divider.sv | 67 ++++++
 rtl/muldiv_hilo_sequencer.sv | 161 ++++++++++++++++
 tb/tb_muldiv_hilo_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide sequencer.
// - muldiv_op_e:  op encoding presented on OpCode by the EX stage
// - muldiv_state_e: sequencer FSM states
// - DIV_ITERS:    restoring-divide iteration count (one quotient bit per cycle)
// - abs32:        two's-complement magnitude; abs32(32'h8000_0000) is 2^31 read unsigned
package muldiv_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MADD  = 4'd5,
    OP_MSUB  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MFHI  = 4'd9,
    OP_MFLO  = 4'd10
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DIV_FIX
  } muldiv_state_e;

  localparam int DIV_ITERS = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_serial_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   i_start            load operands and begin (ignored mid-divide only by the caller)
//   i_dividend         unsigned dividend
//   i_divisor          unsigned divisor (zero gives a meaningless result)
//   o_done             high during the cycle whose clock edge performs the last step;
//                      o_quotient/o_remainder are final from the following cycle
//   o_quotient         quotient
//   o_remainder        remainder
module muldiv_serial_divider
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;   // dividend bits shift out of the top, quotient bits in at the bottom
  logic [31:0] r_dvs;
  logic [5:0]  r_iter;
  logic        r_active;

  logic [32:0] w_shift;
  logic [32:0] w_trial;
  logic        w_fits;

  // Partial remainder stays below the divisor, so the shifted value fits 33 bits
  // and a clear borrow bit means the trial subtraction succeeded.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_trial[32];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_iter   <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_rem    <= '0;
      r_quo    <= i_dividend;
      r_dvs    <= i_divisor;
      r_iter   <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_rem  <= w_fits ? w_trial[31:0] : w_shift[31:0];
      r_quo  <= {r_quo[30:0], w_fits};
      r_iter <= r_iter + 6'd1;
      if (r_iter == 6'(DIV_ITERS - 1)) r_active <= 1'b0;
    end
  end

  assign o_done      = r_active & (r_iter == 6'(DIV_ITERS - 1));
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/muldiv_hilo_sequencer.sv
// Multi-cycle multiply/divide controller owning the Hi/Lo pair.
// Ports:
//   Clk, Rst             clock, async active-low reset
//   OpValid, OpCode      EX-stage op (muldiv_op_e encoding)
//   OperandA, OperandB   forwarded rs / rt
//   Flush                kill the EX-stage op this cycle
//   Stall                hold IF/ID/EX while a muldiv op waits on Busy
//   Busy                 multiply or divide in flight
//   ReadData             MFHI/MFLO result, combinational
//   HiData, LoData       Hi/Lo registers
//   DivByZero            one-cycle pulse after a zero-divisor divide completes
module muldiv_hilo_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        OpValid,
  input  logic [3:0]  OpCode,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  input  logic        Flush,
  output logic        Stall,
  output logic        Busy,
  output logic [31:0] ReadData,
  output logic [31:0] HiData,
  output logic [31:0] LoData,
  output logic        DivByZero
);

  muldiv_state_e r_state, w_next_state;

  logic [31:0] r_hi, r_lo;
  logic [63:0] r_product;
  logic [3:0]  r_op;
  logic [3:0]  r_count;
  logic        r_neg_q, r_neg_r, r_zero_div, r_div_by_zero;
  logic [31:0] r_orig_a;

  logic        w_op_present, w_accept, w_is_mul, w_is_div, w_signed_div;
  logic [63:0] w_prod_s, w_prod_u, w_hilo_next;
  logic        w_div_done;
  logic [31:0] w_quo, w_rem, w_quo_fixed, w_rem_fixed;

  // Every non-NOP op stalls while busy, MT ops included, so Hi/Lo writes stay ordered.
  assign w_op_present = OpValid & (OpCode != OP_NOP) & ~Flush;
  assign Busy         = (r_state != ST_IDLE);
  assign Stall        = w_op_present & Busy;
  assign w_accept     = w_op_present & ~Busy;

  assign w_is_mul = w_accept & ((OpCode == OP_MULT) | (OpCode == OP_MULTU) |
                                (OpCode == OP_MADD) | (OpCode == OP_MSUB));
  assign w_is_div = w_accept & ((OpCode == OP_DIV) | (OpCode == OP_DIVU));
  assign w_signed_div = (OpCode == OP_DIV);

  // Sign-extended 64x64 product truncated to 64 bits equals the signed 32x32 product.
  assign w_prod_s = {{32{OperandA[31]}}, OperandA} * {{32{OperandB[31]}}, OperandB};
  assign w_prod_u = {32'd0, OperandA} * {32'd0, OperandB};

  muldiv_serial_divider u_divider (
    .clk         (Clk),
    .rst_n       (Rst),
    .i_start     (w_is_div),
    .i_dividend  (w_signed_div ? abs32(OperandA) : OperandA),
    .i_divisor   (w_signed_div ? abs32(OperandB) : OperandB),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_quo_fixed = r_neg_q ? (~w_quo + 32'd1) : w_quo;
  assign w_rem_fixed = r_neg_r ? (~w_rem + 32'd1) : w_rem;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_hilo_next = r_product;
    if (r_op == OP_MADD)      w_hilo_next = {r_hi, r_lo} + r_product;
    else if (r_op == OP_MSUB) w_hilo_next = {r_hi, r_lo} - r_product;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mul)      w_next_state = ST_MUL;
        else if (w_is_div) w_next_state = ST_DIV;
      end
      ST_MUL:     if (r_count == 4'd0) w_next_state = ST_IDLE;
      ST_DIV:     if (w_div_done) w_next_state = ST_DIV_FIX;
      ST_DIV_FIX: w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_hi          <= '0;
      r_lo          <= '0;
      r_product     <= '0;
      r_op          <= '0;
      r_count       <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_zero_div    <= 1'b0;
      r_orig_a      <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_div_by_zero <= (r_state == ST_DIV_FIX) & r_zero_div;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && OpCode == OP_MTHI) r_hi <= OperandA;
          if (w_accept && OpCode == OP_MTLO) r_lo <= OperandA;
          if (w_is_mul) begin
            r_product <= (OpCode == OP_MULTU) ? w_prod_u : w_prod_s;
            r_op      <= OpCode;
            r_count   <= 4'(MUL_CYCLES - 1);
          end
          if (w_is_div) begin
            r_neg_q    <= w_signed_div & (OperandA[31] ^ OperandB[31]);
            r_neg_r    <= w_signed_div & OperandA[31];
            r_zero_div <= (OperandB == 32'd0);
            r_orig_a   <= OperandA;
          end
        end
        ST_MUL: begin
          if (r_count == 4'd0) {r_hi, r_lo} <= w_hilo_next;
          else                 r_count <= r_count - 4'd1;
        end
        ST_DIV_FIX: begin
          if (r_zero_div) begin
            r_hi <= r_orig_a;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_rem_fixed;
            r_lo <= w_quo_fixed;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ReadData = '0;
    if (OpValid && !Stall) begin
      if (OpCode == OP_MFHI)      ReadData = r_hi;
      else if (OpCode == OP_MFLO) ReadData = r_lo;
    end
  end

  assign HiData    = r_hi;
  assign LoData    = r_lo;
  assign DivByZero = r_div_by_zero;

endmodule

// File: tb/tb_muldiv_hilo_sequencer.sv
// Directed bench for muldiv_hilo_sequencer with hand-computed expectations.
module tb_muldiv_hilo_sequencer;
  import muldiv_pkg::*;

  logic        Clk, Rst, OpValid, Flush;
  logic [3:0]  OpCode;
  logic [31:0] OperandA, OperandB;
  logic        Stall, Busy, DivByZero;
  logic [31:0] ReadData, HiData, LoData;

  int checks   = 0;
  int failures = 0;

  muldiv_hilo_sequencer #(.MUL_CYCLES(4)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .OpValid   (OpValid),
    .OpCode    (OpCode),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
    .Flush     (Flush),
    .Stall     (Stall),
    .Busy      (Busy),
    .ReadData  (ReadData),
    .HiData    (HiData),
    .LoData    (LoData),
    .DivByZero (DivByZero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Present one op for one edge, then scramble operands to show they are not re-read.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    OpValid  = 1'b1;
    OpCode   = op;
    OperandA = a;
    OperandB = b;
    step();
    OpValid  = 1'b0;
    OpCode   = OP_NOP;
    OperandA = 32'hA5A5_A5A5;
    OperandB = 32'h5A5A_5A5A;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
  endtask

  int n;

  initial begin
    Rst = 1'b0; OpValid = 1'b0; Flush = 1'b0;
    OpCode = OP_NOP; OperandA = '0; OperandB = '0;
    #1;
    check("rst_busy",  32'(Busy), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_dbz",   32'(DivByZero), 32'd0);
    check("rst_hi",    HiData, 32'd0);
    check("rst_lo",    LoData, 32'd0);
    check("rst_rd",    ReadData, 32'd0);
    step(); step();
    Rst = 1'b1;
    step();

    // 1: MULT 200*200
    issue(OP_MULT, 32'h0000_00C8, 32'h0000_00C8);
    count_busy(n);
    check("mul_busy_cycles", 32'(n), 32'd4);
    check("mul_lo", LoData, 32'h0000_9C40);
    check("mul_hi", HiData, 32'd0);

    // 2: MULT 300*100 with dependent MFLO, MTLO stall, flush drops stall
    issue(OP_MULT, 32'h0000_012C, 32'h0000_0064);
    OpValid = 1'b1; OpCode = OP_MTLO; OperandA = 32'hDEAD_BEEF;
    #1;
    check("mtlo_stall", 32'(Stall), 32'd1);
    Flush = 1'b1;
    #1;
    check("flush_no_stall", 32'(Stall), 32'd0);
    Flush = 1'b0; OpCode = OP_MFLO;
    #1;
    n = 0;
    while (Stall === 1'b1 && n < 20) begin
      n++;
      step();
    end
    check("mflo_stall_cycles", 32'(n), 32'd4);
    check("mflo_readdata", ReadData, 32'h0000_7530);
    OpCode = OP_MFHI;
    #1;
    check("mfhi_readdata", ReadData, 32'd0);
    OpValid = 1'b0; OpCode = OP_NOP;
    #1;
    check("idle_readdata", ReadData, 32'd0);
    step();
    check("mtlo_not_taken", LoData, 32'h0000_7530);

    // 3: signed and unsigned divides
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    count_busy(n);
    check("div_busy_cycles", 32'(n), 32'd33);
    check("div_lo", LoData, 32'hFFFF_FFFD);
    check("div_hi", HiData, 32'hFFFF_FFFF);
    check("div_no_dbz", 32'(DivByZero), 32'd0);
    issue(OP_DIVU, 32'h0000_012C, 32'h0000_0064);
    count_busy(n);
    check("divu_lo", LoData, 32'd3);
    check("divu_hi", HiData, 32'd0);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    count_busy(n);
    check("divovf_lo", LoData, 32'h8000_0000);
    check("divovf_hi", HiData, 32'd0);
    check("divovf_no_dbz", 32'(DivByZero), 32'd0);

    // 4: divide by zero, then flushed MULT
    issue(OP_DIVU, 32'h0000_02BC, 32'd0);
    count_busy(n);
    check("dbz_busy_cycles", 32'(n), 32'd33);
    check("dbz_pulse", 32'(DivByZero), 32'd1);
    check("dbz_lo", LoData, 32'hFFFF_FFFF);
    check("dbz_hi", HiData, 32'h0000_02BC);
    step();
    check("dbz_pulse_end", 32'(DivByZero), 32'd0);
    OpValid = 1'b1; OpCode = OP_MULT; OperandA = 32'd9; OperandB = 32'd9; Flush = 1'b1;
    #1;
    check("flush_stall", 32'(Stall), 32'd0);
    step();
    check("flush_busy", 32'(Busy), 32'd0);
    OpValid = 1'b0; OpCode = OP_NOP; Flush = 1'b0;
    step(); step();
    check("flush_busy_later", 32'(Busy), 32'd0);
    check("flush_lo", LoData, 32'hFFFF_FFFF);

    // 5: MTHI/MTLO then accumulate
    issue(OP_MTHI, 32'd5, 32'd0);
    check("mthi_busy", 32'(Busy), 32'd0);
    issue(OP_MTLO, 32'd7, 32'd0);
    check("mthi_hi", HiData, 32'd5);
    check("mtlo_lo", LoData, 32'd7);
    issue(OP_MADD, 32'd2, 32'd3);
    count_busy(n);
    check("madd_busy_cycles", 32'(n), 32'd4);
    check("madd_hi", HiData, 32'd5);
    check("madd_lo", LoData, 32'h0000_000D);
    issue(OP_MSUB, 32'hFFFF_FFFF, 32'd1);
    count_busy(n);
    check("msub_hi", HiData, 32'd5);
    check("msub_lo", LoData, 32'h0000_000E);
    OpValid = 1'b1; OpCode = OP_MFHI;
    #1;
    check("mfhi_after_msub", ReadData, 32'd5);
    OpValid = 1'b0; OpCode = OP_NOP;
    step();

    // 6: async reset mid-divide
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (9) step();
    check("div_inflight_busy", 32'(Busy), 32'd1);
    Rst = 1'b0;
    #1;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_hi", HiData, 32'd0);
    check("midrst_lo", LoData, 32'd0);
    step();
    Rst = 1'b1;
    step();
    check("postrst_busy", 32'(Busy), 32'd0);
    issue(OP_MULT, 32'd3, 32'd4);
    count_busy(n);
    check("postrst_mul_cycles", 32'(n), 32'd4);
    check("postrst_lo", LoData, 32'h0000_000C);
    check("postrst_hi", HiData, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
